demux4_tdm: RTL and testbench
=============================

# demux4_tdm

Time-division 1-to-4 demultiplexer: accepts a single framed stream of words, one slot per valid beat, and distributes slots 0..3 to four registered output lanes y0..y3. It is the receive-side counterpart of the 4-to-1 multiplexer: slot k on the shared line corresponds to input xk and sel = k on the mux side. Captured lanes update together once per complete frame and come with a one-cycle valid pulse.

## Interface
- WIDTH, 8, data width of din and each output lane
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  shared time-multiplexed data word
- din_valid  input  1  din carries a slot word this cycle
- frame_sync  input  1  qualifies the current beat as slot 0; sampled only when din_valid=1
- y0, y1, y2, y3  output  WIDTH  registered lane outputs, slots 0..3 of last complete frame
- out_valid  output  1  one-cycle pulse: y0..y3 just updated with a new frame
- sel  output  2  slot index the next valid beat will be stored to
- locked  output  1  1 while in LOCKED state
- frame_err  output  1  one-cycle pulse: sync arrived mid-frame, partial frame discarded

## Operation
- Reset (rst_n=0, asynchronous): y0..y3=0, out_valid=0, sel=2'b00, locked=0, frame_err=0, shadow registers=0, state=HUNT.
- Internal: 2-bit slot counter (drives sel), three WIDTH-bit shadow registers for slots 0..2, two-state FSM {HUNT, LOCKED}.
- HUNT:
  - din_valid=1, frame_sync=0: beat discarded, no state change.
  - din_valid=1, frame_sync=1: din stored to shadow 0, sel->1, state->LOCKED.
  - frame_sync with din_valid=0: ignored.
- LOCKED, din_valid=1, frame_sync=0:
  - sel=0,1,2: din stored to shadow[sel], sel increments.
  - sel=3: y0..y2 <- shadow 0..2, y3 <- din, all in the same edge; out_valid=1 next cycle; sel wraps to 0; stays LOCKED.
- LOCKED, din_valid=1, frame_sync=1:
  - sel=0: normal slot-0 beat (aligned sync); store to shadow 0, sel->1.
  - sel=1..3: misaligned sync. Partial frame discarded (y0..y3 unchanged, no out_valid), frame_err=1 next cycle, current din stored to shadow 0, sel->1, stays LOCKED.
- LOCKED, din_valid=0: no change; gaps of any length between beats allowed, frame simply resumes.
- Frames after the first do not require frame_sync on slot 0; the counter wrap alone defines the frame boundary.
- y0..y3 hold their value between out_valid pulses; never partially updated.
- Widths: all data paths WIDTH bits, no arithmetic on data; counter is modulo 4.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Latency: slot-3 beat at edge N -> y0..y3 and out_valid=1 visible after edge N; out_valid low again after edge N+1 unless another frame completes at N+1 (impossible at 4 beats/frame, so minimum out_valid spacing is 4 cycles).
- Max throughput: one beat per cycle, one frame per 4 cycles.
- sel reflects the slot for the next beat; updates on the same edge that consumes a beat.
- frame_err and out_valid are mutually exclusive in any cycle.
- Reset asserted mid-frame: shadows and outputs cleared immediately, state HUNT; first frame after release requires frame_sync.
- locked=1 from the edge consuming the first synced beat until reset.

## Test plan
- Reset: hold rst_n=0 mid-stream -> y0..y3=0, sel=0, locked=0, out_valid=0 immediately, without waiting for a clock edge.
- Basic frame, WIDTH=8: sync beat 8'hA0, then 8'hA1, 8'hA2, 8'hA3 on consecutive cycles -> one cycle later y0..y3 = A0,A1,A2,A3, out_valid pulses exactly once, sel back to 0.
- Hunt discard: beats 8'h11, 8'h22 without sync, then synced frame 01,02,03,04 -> y=01,02,03,04; locked rises only with the 01 beat.
- Gaps and wrap: synced frame 10..13 with din_valid low for 3 cycles between each beat, then unsynced frame 20..23 -> two out_valid pulses, second gives y=20,21,22,23.
- Misaligned sync: frame 30,31 then synced beat 40 followed by 41,42,43 -> frame_err pulses once after 40, y stays at previous frame until output 40,41,42,43 with out_valid.
- Reset mid-frame: synced 50,51,52, assert rst_n low for 1 cycle, then unsynced 60..63 -> no out_valid, y0..y3 remain 0, locked=0.

Source files
------------

// File: rtl/demux4_tdm.sv
// ============================================================================
// demux4_tdm : time-division 1-to-4 demultiplexer, frame-aligned lane capture
// Rev 1.0
// ============================================================================
`default_nettype none

module demux4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             out_valid,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             frame_err
);

  localparam logic [0:0] S_HUNT   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;
  logic [WIDTH-1:0] w_sh0_nxt, w_sh1_nxt, w_sh2_nxt;
  logic [WIDTH-1:0] r_y0, r_y1, r_y2, r_y3;
  logic [WIDTH-1:0] w_y0_nxt, w_y1_nxt, w_y2_nxt, w_y3_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: once locked, only reset returns to HUNT
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_HUNT && din_valid && frame_sync) begin
      w_state_nxt = S_LOCKED;
    end
  end

  // Slot routing: a misaligned sync restarts the frame at slot 0
  always_comb begin
    w_sel_nxt       = r_sel;
    w_sh0_nxt       = r_sh0;
    w_sh1_nxt       = r_sh1;
    w_sh2_nxt       = r_sh2;
    w_y0_nxt        = r_y0;
    w_y1_nxt        = r_y1;
    w_y2_nxt        = r_y2;
    w_y3_nxt        = r_y3;
    w_out_valid_nxt = 1'b0;
    w_frame_err_nxt = 1'b0;
    if (din_valid) begin
      if (r_state == S_HUNT) begin
        if (frame_sync) begin
          w_sh0_nxt = din;
          w_sel_nxt = 2'd1;
        end
      end else if (frame_sync && r_sel != 2'd0) begin
        w_frame_err_nxt = 1'b1;
        w_sh0_nxt       = din;
        w_sel_nxt       = 2'd1;
      end else begin
        w_sel_nxt = r_sel + 2'd1;
        case (r_sel)
          2'd0: w_sh0_nxt = din;
          2'd1: w_sh1_nxt = din;
          2'd2: w_sh2_nxt = din;
          2'd3: begin
            w_y0_nxt        = r_sh0;
            w_y1_nxt        = r_sh1;
            w_y2_nxt        = r_sh2;
            w_y3_nxt        = din;
            w_out_valid_nxt = 1'b1;
          end
          default: w_sel_nxt = 2'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= 2'd0;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_sh2       <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_y3        <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sel       <= w_sel_nxt;
      r_sh0       <= w_sh0_nxt;
      r_sh1       <= w_sh1_nxt;
      r_sh2       <= w_sh2_nxt;
      r_y0        <= w_y0_nxt;
      r_y1        <= w_y1_nxt;
      r_y2        <= w_y2_nxt;
      r_y3        <= w_y3_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign y0        = r_y0;
  assign y1        = r_y1;
  assign y2        = r_y2;
  assign y3        = r_y3;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign sel       = r_sel;
  assign locked    = (r_state == S_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_demux4_tdm.sv
// ============================================================================
// tb_demux4_tdm : directed + randomized check of demux4_tdm against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_demux4_tdm;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic             out_valid;
  logic [1:0]       sel;
  logic             locked;
  logic             frame_err;

  int n_checks;
  int n_errors;

  // Reference model: the partial frame is just a queue of collected words
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_y[4];
  logic             m_locked;
  logic             m_ov;
  logic             m_err;

  demux4_tdm #(.WIDTH(WIDTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .out_valid  (out_valid),
    .sel        (sel),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    m_locked = 1'b0;
    m_ov     = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_beat(input logic v, input logic s, input logic [WIDTH-1:0] d);
    m_ov  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_q.delete();
          m_q.push_back(d);
          m_locked = 1'b1;
        end
      end else begin
        if (s && m_q.size() != 0) begin
          m_err = 1'b1;
          m_q.delete();
        end
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
          m_ov = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    chk("y0", 32'(y0), 32'(m_y[0]));
    chk("y1", 32'(y1), 32'(m_y[1]));
    chk("y2", 32'(y2), 32'(m_y[2]));
    chk("y3", 32'(y3), 32'(m_y[3]));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("sel", 32'(sel), 32'(m_q.size()));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    model_beat(v, s, d);
    #1;
    check_all();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, WIDTH'($urandom));
  endtask

  // Reset is checked before any clock edge to prove it is asynchronous
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Basic frame
    step(1, 1, 8'hA0); step(1, 0, 8'hA1); step(1, 0, 8'hA2); step(1, 0, 8'hA3);
    step(0, 0, 8'h00);
    chk("basic_y0", 32'(y0), 32'h0A0);
    chk("basic_y3", 32'(y3), 32'h0A3);

    // Hunt discard
    do_reset();
    step(1, 0, 8'h11); step(1, 0, 8'h22);
    step(1, 1, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03); step(1, 0, 8'h04);
    chk("hunt_y2", 32'(y2), 32'h03);

    // Gaps and wrap
    step(1, 1, 8'h10); gap(3); step(1, 0, 8'h11); gap(3);
    step(1, 0, 8'h12); gap(3); step(1, 0, 8'h13); gap(3);
    step(1, 0, 8'h20); step(1, 0, 8'h21); step(1, 0, 8'h22); step(1, 0, 8'h23);
    chk("wrap_y0", 32'(y0), 32'h20);

    // Misaligned sync
    step(1, 0, 8'h30); step(1, 0, 8'h31);
    step(1, 1, 8'h40);
    chk("misalign_err", 32'(frame_err), 32'd1);
    chk("misalign_hold", 32'(y1), 32'h21);
    step(1, 0, 8'h41); step(1, 0, 8'h42); step(1, 0, 8'h43);
    chk("misalign_y", 32'({y0, y1, y2, y3}), 32'h40414243);

    // Reset mid-frame
    step(1, 1, 8'h50); step(1, 0, 8'h51); step(1, 0, 8'h52);
    do_reset();
    step(1, 0, 8'h60); step(1, 0, 8'h61); step(1, 0, 8'h62); step(1, 0, 8'h63);
    chk("rst_locked", 32'(locked), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
             ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
             WIDTH'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
